// File: rtl/dlp_icache.sv
// dlp_icache: direct-mapped, read-only instruction cache between the display-list
// processor and the SDRAM burst port. Hits return one word per cycle; a miss fetches
// the whole line as one SDRAM burst.
// Optional feature: DLP_ICACHE_EARLY_RESTART_EN returns the requested word the cycle
// after it arrives during a fill instead of waiting for the burst to complete.
module dlp_icache #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned NUM_LINES  = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] dlp_addr,
  input  logic                  dlp_req,
  input  logic                  dlp_flush,
  output logic [31:0]           dlp_instr,
  output logic                  dlp_valid,
  output logic                  dlp_sdram_req,
  output logic [31:0]           dlp_sdram_addr,
  input  logic                  dlp_sdram_ack,
  input  logic [31:0]           dlp_sdram_data,
  input  logic                  dlp_sdram_valid,
  input  logic                  dlp_sdram_complete
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned WA_W  = ADDR_WIDTH - 2;
  localparam int unsigned TAG_W = WA_W - OFF_W - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, FILL, RESPOND} state_t;

  state_t state, state_nx;

  // Word addresses (byte offset bits dropped)
  logic [WA_W-1:0]  req_wa;
  logic [WA_W-1:0]  pend_wa;
  logic [WA_W-1:0]  issue_wa;
  logic             pend_v;

  logic [31:0]      rd_data;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      cap_word;
  logic [NUM_LINES-1:0] line_valid;
  logic [OFF_W-1:0] cnt;
  logic             fill_flushed;

  logic issue, req_taken, pend_take, pend_set, miss_start;
  logic hit, fill_beat, want_beat, fill_done;

  logic [31:0]      data_ram [LINE_WORDS*NUM_LINES];
  logic [TAG_W-1:0] tag_ram  [NUM_LINES];

  logic [OFF_W-1:0] req_off, issue_off;
  logic [IDX_W-1:0] req_idx, issue_idx;
  logic [TAG_W-1:0] req_tag;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic unused_addr_bits;

  assign req_off   = req_wa[OFF_W-1:0];
  assign req_idx   = req_wa[OFF_W +: IDX_W];
  assign req_tag   = req_wa[WA_W-1 -: TAG_W];
  assign issue_off = issue_wa[OFF_W-1:0];
  assign issue_idx = issue_wa[OFF_W +: IDX_W];
  assign line_addr = {req_wa[WA_W-1:OFF_W], {(OFF_W+2){1'b0}}};
  assign unused_addr_bits = ^dlp_addr[1:0];

  assign hit       = line_valid[req_idx] && (rd_tag == req_tag);
  assign fill_beat = (state == FILL) && dlp_sdram_valid;
  assign want_beat = fill_beat && (cnt == req_off);
  assign fill_done = (state == FILL) && dlp_sdram_complete;

  // A request not consumed directly goes to the one-deep pending slot if it is free
  // (or being drained this cycle); anything beyond that is dropped.
  assign pend_set  = dlp_req && !req_taken && (!pend_v || pend_take);

`ifdef DLP_ICACHE_EARLY_RESTART_EN
  logic early_pulse;

  // Early-restart response pulse, one cycle after the requested word arrives
  always_ff @(posedge clock or posedge reset) begin
    if (reset) early_pulse <= 1'b0;
    else       early_pulse <= want_beat && !dlp_sdram_complete;
  end
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state, RAM read issue and output decode
  always_comb begin
    state_nx      = state;
    issue         = 1'b0;
    issue_wa      = dlp_addr[ADDR_WIDTH-1:2];
    req_taken     = 1'b0;
    pend_take     = 1'b0;
    miss_start    = 1'b0;
    dlp_valid     = 1'b0;
    dlp_instr     = '0;
    dlp_sdram_req = 1'b0;
`ifdef DLP_ICACHE_EARLY_RESTART_EN
    if (early_pulse) begin
      dlp_valid = 1'b1;
      dlp_instr = cap_word;
    end
`endif
    case (state)
      IDLE: begin
        if (pend_v) begin
          issue     = 1'b1;
          issue_wa  = pend_wa;
          pend_take = 1'b1;
          state_nx  = LOOKUP;
        end else if (dlp_req) begin
          issue     = 1'b1;
          req_taken = 1'b1;
          state_nx  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          dlp_valid = 1'b1;
          dlp_instr = rd_data;
          if (dlp_req) begin
            issue     = 1'b1;
            req_taken = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          miss_start = 1'b1;
          state_nx   = MISS_REQ;
        end
      end
      MISS_REQ: begin
        dlp_sdram_req = 1'b1;
        if (dlp_sdram_ack) state_nx = FILL;
      end
      FILL: begin
        if (fill_done) begin
`ifdef DLP_ICACHE_EARLY_RESTART_EN
          // Word landing on the completing beat is answered via RESPOND; otherwise
          // it was already answered and any pending request is picked up from IDLE.
          state_nx = want_beat ? RESPOND : IDLE;
`else
          state_nx = RESPOND;
`endif
        end
      end
      RESPOND: begin
        dlp_valid = 1'b1;
        dlp_instr = cap_word;
        if (pend_v) begin
          issue     = 1'b1;
          issue_wa  = pend_wa;
          pend_take = 1'b1;
          state_nx  = LOOKUP;
        end else if (dlp_req) begin
          issue     = 1'b1;
          req_taken = 1'b1;
          state_nx  = LOOKUP;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_wa         <= '0;
      pend_wa        <= '0;
      pend_v         <= 1'b0;
      cnt            <= '0;
      cap_word       <= '0;
      fill_flushed   <= 1'b0;
      line_valid     <= '0;
      dlp_sdram_addr <= '0;
    end else begin
      if (issue) req_wa <= issue_wa;
      if (pend_take) pend_v <= 1'b0;
      if (pend_set) begin
        pend_v  <= 1'b1;
        pend_wa <= dlp_addr[ADDR_WIDTH-1:2];
      end
      if (miss_start) begin
        cnt            <= '0;
        dlp_sdram_addr <= 32'(line_addr);
      end else if (fill_beat) begin
        cnt <= cnt + 1'b1;
      end
      if (want_beat) cap_word <= dlp_sdram_data;
      if (miss_start)
        fill_flushed <= 1'b0;
      else if (dlp_flush && (state == MISS_REQ || state == FILL))
        fill_flushed <= 1'b1;
      if (dlp_flush)
        line_valid <= '0;
      else if (fill_done && !fill_flushed)
        line_valid[req_idx] <= 1'b1;
    end
  end

  // Data and tag RAMs: fill writes, synchronous lookup reads
  always_ff @(posedge clock) begin
    if (fill_beat) data_ram[{req_idx, cnt}] <= dlp_sdram_data;
    if (fill_done) tag_ram[req_idx] <= req_tag;
    if (issue) begin
      rd_data <= data_ram[{issue_idx, issue_off}];
      rd_tag  <= tag_ram[issue_idx];
    end
  end

endmodule

// File: tb/tb_dlp_icache.sv
// tb_dlp_icache: randomized self-checking bench for dlp_icache with an SDRAM responder
// and a line-level cache reference model (valid/tag per index, data = function of address).
module tb_dlp_icache;

  localparam int unsigned LW   = 8;
  localparam int unsigned NL   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned OFFB = 2 + $clog2(LW);
  localparam int unsigned IDXB = $clog2(NL);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] dlp_addr = '0;
  logic          dlp_req = 1'b0;
  logic          flush_main = 1'b0;
  logic          flush_fill = 1'b0;
  logic          dlp_flush;
  logic [31:0]   dlp_instr;
  logic          dlp_valid;
  logic          dlp_sdram_req;
  logic [31:0]   dlp_sdram_addr;
  logic          sd_ack = 1'b0;
  logic [31:0]   sd_data = '0;
  logic          sd_valid = 1'b0;
  logic          sd_complete = 1'b0;

  assign dlp_flush = flush_main | flush_fill;

  dlp_icache #(.LINE_WORDS(LW), .NUM_LINES(NL), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .dlp_addr(dlp_addr), .dlp_req(dlp_req), .dlp_flush(dlp_flush),
    .dlp_instr(dlp_instr), .dlp_valid(dlp_valid),
    .dlp_sdram_req(dlp_sdram_req), .dlp_sdram_addr(dlp_sdram_addr),
    .dlp_sdram_ack(sd_ack), .dlp_sdram_data(sd_data),
    .dlp_sdram_valid(sd_valid), .dlp_sdram_complete(sd_complete)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) * 32'h0019_660D + 32'h3C6E_F35F;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'(LW*4-1);
  endfunction

  function automatic int unsigned idx_of(input logic [31:0] a);
    return int'((a >> OFFB) % NL);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (OFFB + IDXB);
  endfunction

  // Reference model: one valid bit and tag per line
  bit          mval [NL];
  logic [31:0] mtag [NL];

  function automatic bit model_miss(input logic [31:0] a);
    return !(mval[idx_of(a)] && mtag[idx_of(a)] == tag_of(a));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) mval[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [31:0] a);
    mval[idx_of(a)] = 1'b1;
    mtag[idx_of(a)] = tag_of(a);
  endtask

  // Response monitor
  typedef struct { logic [31:0] data; int unsigned at; } resp_t;
  resp_t resp_q[$];
  always @(negedge clock) if (!reset && dlp_valid) resp_q.push_back('{dlp_instr, cyc});

  // SDRAM responder: random ack delay, random beat gaps, complete with or after last beat
  logic [31:0] bq[$];
  int unsigned bursts = 0;
  int unsigned beats = 0;
  int unsigned sd_limit = 0;
  int unsigned flush_at_beat = 0;
  logic        sd_busy = 1'b0;

  initial begin
    logic [31:0] base;
    bit          tail;
    forever begin
      @(negedge clock);
      if (dlp_sdram_req && !reset) begin
        sd_busy = 1'b1;
        base = dlp_sdram_addr;
        bq.push_back(base);
        bursts++;
        tail = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) @(negedge clock);
        sd_ack = 1'b1;
        @(negedge clock);
        sd_ack = 1'b0;
        for (int w = 0; w < LW; w++) begin
          if (sd_limit != 0 && w >= int'(sd_limit)) break;
          repeat ($urandom_range(0, 1)) @(negedge clock);
          sd_valid    = 1'b1;
          sd_data     = mem_word(base + 32'(4*w));
          sd_complete = (w == LW-1) && !tail;
          flush_fill  = (flush_at_beat != 0) && (w == int'(flush_at_beat));
          beats++;
          @(negedge clock);
          sd_valid = 1'b0; sd_complete = 1'b0; flush_fill = 1'b0;
        end
        if (tail && sd_limit == 0) begin
          sd_complete = 1'b1;
          @(negedge clock);
          sd_complete = 1'b0;
        end
        sd_busy = 1'b0;
      end
    end
  end

  task automatic pulse_req(input logic [31:0] a, output int unsigned at);
    @(negedge clock);
    dlp_addr = a; dlp_req = 1'b1; at = cyc;
    @(negedge clock);
    dlp_req = 1'b0;
  endtask

  task automatic wait_n(input int unsigned n);
    for (int t = 0; t < 400 && resp_q.size() < int'(n); t++) @(negedge clock);
    check("resp_cnt", resp_q.size(), n);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200 && sd_busy; t++) @(negedge clock);
    check("sd_idle", {31'd0, sd_busy}, 32'd0);
  endtask

  task automatic flush_pulse();
    @(negedge clock); flush_main = 1'b1;
    @(negedge clock); flush_main = 1'b0;
    model_clear();
  endtask

  task automatic do_txn(input logic [31:0] a, input bit fl);
    bit miss;
    int unsigned at, b0;
    resp_q.delete(); bq.delete();
    b0 = bursts;
    miss = model_miss(a);
    flush_at_beat = (fl && miss) ? 3 : 0;
    pulse_req(a, at);
    wait_n(1);
    wait_idle();
    flush_at_beat = 0;
    repeat (2) @(negedge clock);
    check("resp_final", resp_q.size(), 1);
    check("bursts", bursts - b0, 32'(miss));
    if (miss && bq.size() > 0) check("burst_addr", bq[0], line_of(a));
    if (resp_q.size() > 0) begin
      check("data", resp_q[0].data, mem_word(a));
      if (!miss) check("hit_lat", resp_q[0].at - at, 1);
    end
    if (miss) begin
      if (fl) model_clear();
      else    model_fill(a);
    end
  endtask

  task automatic stream(input logic [31:0] base, input int unsigned n);
    int unsigned ats[LW];
    int unsigned b0;
    if (model_miss(base)) do_txn(base, 1'b0);
    resp_q.delete();
    b0 = bursts;
    @(negedge clock);
    for (int i = 0; i < int'(n); i++) begin
      dlp_addr = base + 32'(4*i); dlp_req = 1'b1; ats[i] = cyc;
      @(negedge clock);
    end
    dlp_req = 1'b0;
    wait_n(n);
    check("stream_bursts", bursts - b0, 0);
    for (int i = 0; i < int'(n) && i < resp_q.size(); i++) begin
      check("stream_data", resp_q[i].data, mem_word(base + 32'(4*i)));
      check("stream_lat", resp_q[i].at - ats[i], 1);
    end
  endtask

  task automatic pair(input logic [31:0] a, input logic [31:0] b);
    int unsigned at, at2, b0, bt0;
    bit miss_b;
    flush_pulse();
    resp_q.delete(); bq.delete();
    b0 = bursts; bt0 = beats;
    pulse_req(a, at);
    for (int t = 0; t < 200 && beats < bt0 + 2; t++) @(negedge clock);
    pulse_req(b, at2);
    model_fill(a);
    miss_b = model_miss(b);
    if (miss_b) model_fill(b);
    wait_n(2);
    wait_idle();
    check("pair_bursts", bursts - b0, 32'(1 + int'(miss_b)));
    if (bq.size() > 0) check("pair_addr0", bq[0], line_of(a));
    if (miss_b && bq.size() > 1) check("pair_addr1", bq[1], line_of(b));
    if (resp_q.size() > 1) begin
      check("pair_data0", resp_q[0].data, mem_word(a));
      check("pair_data1", resp_q[1].data, mem_word(b));
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return (32'($urandom_range(0, 3)) << (OFFB + IDXB)) |
           (32'($urandom_range(8, 11)) << OFFB) |
           (32'($urandom_range(0, LW-1)) << 2);
  endfunction

  initial begin
    int unsigned at, b0;
    logic [31:0] a, b;
    model_clear();
    repeat (3) @(negedge clock);
    check("rst_valid", {31'd0, dlp_valid}, 0);
    check("rst_sdram_req", {31'd0, dlp_sdram_req}, 0);
    check("rst_instr", dlp_instr, 0);
    check("rst_sdram_addr", dlp_sdram_addr, 0);
    reset = 1'b0;

    // Cold miss, hit, streaming, conflict
    do_txn(32'h100, 1'b0);
    do_txn(32'h11C, 1'b0);
    stream(32'h100, LW);
    do_txn(32'h500, 1'b0);
    do_txn(32'h100, 1'b0);
    // Flush between and during fills
    do_txn(32'h100, 1'b0);
    flush_pulse();
    do_txn(32'h100, 1'b0);
    do_txn(32'h144, 1'b1);
    do_txn(32'h144, 1'b0);
    // Pending request during fill
    pair(32'h200, 32'h204);
    pair(32'h100, 32'h500);

    // Reset in the middle of a fill after three beats
    flush_pulse();
    resp_q.delete();
    sd_limit = 3;
    b0 = bursts;
    pulse_req(32'h108, at);
    for (int t = 0; t < 200 && !(bursts > b0 && !sd_busy); t++) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_sdram_req", {31'd0, dlp_sdram_req}, 0);
    check("midrst_valid", {31'd0, dlp_valid}, 0);
`ifdef DLP_ICACHE_EARLY_RESTART_EN
    check("midrst_resp", resp_q.size(), 1);
    if (resp_q.size() > 0) check("midrst_early_data", resp_q[0].data, mem_word(32'h108));
`else
    check("midrst_resp", resp_q.size(), 0);
`endif
    reset = 1'b0;
    sd_limit = 0;
    model_clear();
    do_txn(32'h108, 1'b0);

    // Randomized mix
    for (int i = 0; i < 120; i++) begin
      a = rand_addr();
      case ($urandom_range(0, 9))
        5: do_txn(a, 1'b1);
        6: flush_pulse();
        7: stream(line_of(a), $urandom_range(2, LW));
        8: begin
          b = $urandom_range(0, 1) ? (line_of(a) + 32'(4*$urandom_range(0, LW-1))) : rand_addr();
          pair(a, b);
        end
        default: do_txn(a, 1'b0);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
